// File: rtl/nn_sched_pkg.sv
// Shared scheduler types: FSM state encoding, default sizing
// constants and a one-hot helper used by the layer sequencer.
package nn_sched_pkg;

  localparam int MAX_STAGES  = 16;
  localparam int TIMEOUT_DEF = 4096;
  localparam int CW_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    START,
    WAIT,
    CACHE,
    DONE
  } state_t;

  function automatic logic [MAX_STAGES-1:0] onehot(
    input logic [3:0] i
  );
    logic [MAX_STAGES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the frame trigger.
// Ports: clk, rst (sync, active-high), d (level in), rise (1-cycle hit).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic armed_q;

  // armed_q blocks a false edge in the first cycle after reset
  // when the trigger is already high.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= d;
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & d & ~prev_q;

endmodule

// File: rtl/layer_sequencer.sv
// Frame sequencer: on each sample_clk edge shifts the input buffers,
// starts each conv stage in turn, pulses per-stage activation caches,
// and reports frame latency plus sticky overrun/timeout status.
// Ports: clk, rst, sample_clk, stage_done[N], clr_stats in;
//   lsb_clk, stage_start[N], cache_clk[N], busy, frame_done,
//   overrun, timeout_err, last_cycles[CW], max_cycles[CW] out.
module layer_sequencer
  import nn_sched_pkg::*;
#(
  parameter int                  N_STAGES   = 8,
  parameter logic [N_STAGES-1:0] CACHE_MASK = '0,
  parameter int                  TIMEOUT    = TIMEOUT_DEF,
  parameter int                  CW         = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic [N_STAGES-1:0] stage_done,
  input  logic                clr_stats,
  output logic                lsb_clk,
  output logic [N_STAGES-1:0] stage_start,
  output logic [N_STAGES-1:0] cache_clk,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err,
  output logic [CW-1:0]       last_cycles,
  output logic [CW-1:0]       max_cycles
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(N_STAGES - 1);
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);
  localparam logic [MAX_STAGES-1:0] MASK16 =
    MAX_STAGES'(CACHE_MASK);

  state_t state_q;
  state_t state_d;
  logic [3:0] idx_q;
  logic [3:0] idx_d;

  logic rise;
  logic [MAX_STAGES-1:0] done16;
  logic done_now;
  logic last_stage;
  logic tmo_hit;
  logic ovr_hit;
  logic upd;

  logic [WW-1:0] wcnt_q;
  logic [CW-1:0] cnt_q;
  logic ovr_q;
  logic tmo_q;

  logic lsb_d;
  logic [N_STAGES-1:0] start_d;
  logic [N_STAGES-1:0] cache_d;
  logic fd_d;
  logic busy_d;
  logic [MAX_STAGES-1:0] oh;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (sample_clk),
    .rise (rise)
  );

  assign done16     = MAX_STAGES'(stage_done);
  assign done_now   = (state_q == WAIT) && done16[idx_q];
  assign last_stage = (idx_q == LAST_IDX);
  assign ovr_hit    = rise && (state_q != IDLE);
  assign tmo_hit    = !rst && (state_q == WAIT) &&
                      !done16[idx_q] && (wcnt_q == TMO_LAST);
  // An edge arriving in DONE aborts the stats update.
  assign upd        = (state_q == DONE) && !rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A new edge always wins: restart from SHIFT even mid-frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (rise) begin
      state_d = SHIFT;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        SHIFT: begin
          state_d = START;
          idx_d   = '0;
        end
        START: state_d = WAIT;
        WAIT: begin
          if (done_now) begin
            if (MASK16[idx_q]) begin
              state_d = CACHE;
            end else if (last_stage) begin
              state_d = DONE;
            end else begin
              state_d = START;
              idx_d   = idx_q + 4'd1;
            end
          end else if (tmo_hit) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        CACHE: begin
          if (last_stage) begin
            state_d = DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + 4'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pulses are decoded from the next state and registered,
  // so they line up with the state they belong to.
  always_comb begin
    oh      = onehot(idx_d);
    lsb_d   = (state_d == SHIFT);
    start_d = '0;
    cache_d = '0;
    if (state_d == START) begin
      start_d = oh[N_STAGES-1:0];
    end
    if (state_d == CACHE) begin
      cache_d = oh[N_STAGES-1:0];
    end
    fd_d    = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_clk     <= 1'b0;
      stage_start <= '0;
      cache_clk   <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      lsb_clk     <= lsb_d;
      stage_start <= start_d;
      cache_clk   <= cache_d;
      frame_done  <= fd_d;
      busy        <= busy_d;
    end
  end

  // Wait timer restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if (state_q == WAIT) begin
      wcnt_q <= wcnt_q + 1'b1;
    end else begin
      wcnt_q <= '0;
    end
  end

  // Frame counter: 0 at the edge cycle, so load 1 for the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= CW'(1);
    end else if (state_q != IDLE && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky flags and max: a set in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
      last_cycles <= '0;
      max_cycles  <= '0;
    end else begin
      ovr_q <= ovr_hit | (ovr_q & ~clr_stats);
      tmo_q <= tmo_hit | (tmo_q & ~clr_stats);
      if (upd) begin
        last_cycles <= cnt_q;
        if (clr_stats || cnt_q > max_cycles) begin
          max_cycles <= cnt_q;
        end
      end else if (clr_stats) begin
        max_cycles <= '0;
      end
    end
  end

  assign overrun     = ovr_q;
  assign timeout_err = tmo_q | tmo_hit;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a per-cycle vector table for
// a nominal frame plus hand-written overrun/timeout/reset sequences.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_clk;
  logic [1:0]  stage_done;
  logic        clr_stats;
  logic        lsb_clk;
  logic [1:0]  stage_start;
  logic [1:0]  cache_clk;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] last_cycles;
  logic [15:0] max_cycles;

  layer_sequencer #(
    .N_STAGES   (2),
    .CACHE_MASK (2'b01),
    .TIMEOUT    (8),
    .CW         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_clk  (sample_clk),
    .stage_done  (stage_done),
    .clr_stats   (clr_stats),
    .lsb_clk     (lsb_clk),
    .stage_start (stage_start),
    .cache_clk   (cache_clk),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .last_cycles (last_cycles),
    .max_cycles  (max_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sc;
    logic [1:0] done;
    logic       lsb;
    logic [1:0] st;
    logic [1:0] ca;
    logic       fd;
    logic       bsy;
  } vec_t;

  vec_t vec [13];

  int n_chk;
  int n_fail;
  int cd [2];
  int resp_d;
  logic [1:0] resp_en;
  bit auto_resp;
  bit hold;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stage model: done pulses resp_d cycles after a start,
  // or stays high when hold is set.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      for (int i = 0; i < 2; i++) begin
        stage_done[i] = hold;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) stage_done[i] = resp_en[i] | hold;
        end
        if (stage_start[i]) cd[i] = resp_d;
      end
    end
    #1;
  endtask

  task automatic start_frame();
    sample_clk = 1'b0;
    tick();
    sample_clk = 1'b1;
    #1;
  endtask

  task automatic run_frame(input int d, output int rel);
    resp_d = d;
    rel    = -1;
    start_frame();
    for (int k = 1; k <= 40 && rel < 0; k++) begin
      tick();
      sample_clk = 1'b0;
      if (frame_done) rel = k;
    end
    if (rel < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_wait: got no frame_done expected one");
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    bit seen;
    n_chk      = 0;
    n_fail     = 0;
    cd[0]      = 0;
    cd[1]      = 0;
    resp_d     = 3;
    resp_en    = 2'b11;
    auto_resp  = 1'b0;
    hold       = 1'b0;
    rst        = 1'b1;
    sample_clk = 1'b0;
    stage_done = 2'b00;
    clr_stats  = 1'b0;

    // t: sc done | lsb start cache fd busy
    vec[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[4]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1};
    vec[7]  = '{1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};
    vec[8]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[10] = '{1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vec[11] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vec[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    tick();
    tick();
    check("rst_lsb", 32'(lsb_clk), 32'(0));
    check("rst_start", 32'(stage_start), 32'(0));
    check("rst_cache", 32'(cache_clk), 32'(0));
    check("rst_fd", 32'(frame_done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ovr", 32'(overrun), 32'(0));
    check("rst_tmo", 32'(timeout_err), 32'(0));
    check("rst_last", 32'(last_cycles), 32'(0));
    check("rst_max", 32'(max_cycles), 32'(0));
    rst = 1'b0;
    tick();

    // Nominal frame, 3-cycle stage latency
    sample_clk = 1'b0;
    tick();
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      sample_clk = vec[k].sc;
      stage_done = vec[k].done;
      #1;
      check($sformatf("t%0d_lsb", k), 32'(lsb_clk), 32'(vec[k].lsb));
      check($sformatf("t%0d_start", k), 32'(stage_start), 32'(vec[k].st));
      check($sformatf("t%0d_cache", k), 32'(cache_clk), 32'(vec[k].ca));
      check($sformatf("t%0d_fd", k), 32'(frame_done), 32'(vec[k].fd));
      check($sformatf("t%0d_busy", k), 32'(busy), 32'(vec[k].bsy));
    end
    check("nom_last", 32'(last_cycles), 32'(11));
    check("nom_max", 32'(max_cycles), 32'(11));
    check("nom_ovr", 32'(overrun), 32'(0));

    // Overrun: second edge at t+4
    auto_resp = 1'b1;
    resp_d    = 3;
    resp_en   = 2'b11;
    start_frame();
    tick();
    sample_clk = 1'b0;
    tick();
    tick();
    tick();
    sample_clk = 1'b1;
    #1;
    check("ovr_pre", 32'(overrun), 32'(0));
    tick();
    sample_clk = 1'b0;
    check("ovr_lsb_t5", 32'(lsb_clk), 32'(1));
    check("ovr_flag", 32'(overrun), 32'(1));
    check("ovr_busy", 32'(busy), 32'(1));
    seen = frame_done;
    for (int k = 6; k <= 14; k++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    check("ovr_no_fd", 32'(seen), 32'(0));
    tick();
    check("ovr_fd_t15", 32'(frame_done), 32'(1));
    tick();
    check("ovr_last", 32'(last_cycles), 32'(11));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_ovr", 32'(overrun), 32'(0));
    check("clr_max0", 32'(max_cycles), 32'(0));

    // Timeout: stage 0 never answers
    resp_en = 2'b00;
    start_frame();
    tick();
    sample_clk = 1'b0;
    seen = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (stage_start[1]) seen = 1'b1;
    end
    check("tmo_early", 32'(timeout_err), 32'(0));
    tick();
    check("tmo_t10", 32'(timeout_err), 32'(1));
    check("tmo_busy_t10", 32'(busy), 32'(1));
    tick();
    check("tmo_busy_t11", 32'(busy), 32'(0));
    check("tmo_sticky", 32'(timeout_err), 32'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      if (stage_start[1] || frame_done) seen = 1'b1;
    end
    check("tmo_no_stage1", 32'(seen), 32'(0));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_tmo", 32'(timeout_err), 32'(0));

    // stage_done held high through START
    resp_en = 2'b11;
    hold    = 1'b1;
    start_frame();
    tick();
    sample_clk = 1'b0;
    check("hold_lsb", 32'(lsb_clk), 32'(1));
    tick();
    check("hold_start0", 32'(stage_start), 32'(1));
    tick();
    check("hold_t3_cache", 32'(cache_clk), 32'(0));
    tick();
    check("hold_t4_cache", 32'(cache_clk), 32'(1));
    tick();
    check("hold_start1", 32'(stage_start), 32'(2));
    tick();
    tick();
    check("hold_fd_t7", 32'(frame_done), 32'(1));
    tick();
    check("hold_last", 32'(last_cycles), 32'(7));
    hold = 1'b0;
    tick();

    // Stats: frames of 11 then 9 cycles
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("st_max_clr", 32'(max_cycles), 32'(0));
    run_frame(3, rel);
    check("st_rel11", 32'(rel), 32'(11));
    check("st_last11", 32'(last_cycles), 32'(11));
    run_frame(2, rel);
    check("st_rel9", 32'(rel), 32'(9));
    check("st_last9", 32'(last_cycles), 32'(9));
    check("st_max11", 32'(max_cycles), 32'(11));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("st_max_clr2", 32'(max_cycles), 32'(0));
    check("st_last_kept", 32'(last_cycles), 32'(9));

    // Reset in WAIT, trigger already high when reset drops
    resp_d = 3;
    start_frame();
    tick();
    sample_clk = 1'b0;
    tick();
    tick();
    check("mr_busy_wait", 32'(busy), 32'(1));
    rst        = 1'b1;
    sample_clk = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_lsb", 32'(lsb_clk), 32'(0));
    check("mr_start", 32'(stage_start), 32'(0));
    check("mr_cache", 32'(cache_clk), 32'(0));
    check("mr_fd", 32'(frame_done), 32'(0));
    check("mr_busy", 32'(busy), 32'(0));
    check("mr_tmo", 32'(timeout_err), 32'(0));
    check("mr_last", 32'(last_cycles), 32'(0));
    tick();
    check("mr_no_edge", 32'(busy), 32'(0));
    tick();
    check("mr_no_edge2", 32'(busy), 32'(0));
    run_frame(3, rel);
    check("mr_rel", 32'(rel), 32'(11));
    check("mr_clean_last", 32'(last_cycles), 32'(11));
    check("mr_clean_ovr", 32'(overrun), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 8: number of sequenced conv stages (1..16).
REQ-002 SHALL have parameter CACHE_MASK, default 0: per-stage bit; when bit i is 1, an activation-cache clock pulse follows stage i.
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum wait cycles per stage.
REQ-004 SHALL have parameter CW, default 16: width of the cycle counters.
REQ-005 SHALL have port clk  in  1: clock.
REQ-006 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-007 SHALL have port sample_clk  in  1: audio-rate frame trigger, synchronous to clk.
REQ-008 SHALL have port stage_done  in  N_STAGES: out_v of each stage.
REQ-009 SHALL have port clr_stats  in  1: clears sticky flags and max_cycles.
REQ-010 SHALL have port lsb_clk  out  1: pulse that advances the input shift buffers.
REQ-011 SHALL have port stage_start  out  N_STAGES: one-hot, one-cycle reset/start pulse to each stage.
REQ-012 SHALL have port cache_clk  out  N_STAGES: one-cycle activation-cache clock pulse per stage.
REQ-013 SHALL have ports busy, frame_done, overrun, timeout_err  out  1 each: status.
REQ-014 SHALL have ports last_cycles, max_cycles  out  CW each: frame latency statistics.

Function
REQ-015 SHALL detect a sample_clk rising edge as sample_clk=1 with the registered previous value 0; the detection cycle is cycle t.
REQ-016 SHALL use states IDLE, SHIFT, START, WAIT, CACHE, DONE, with a stage index idx.
REQ-017 SHALL go from IDLE on an edge to SHIFT at t+1, driving lsb_clk=1 for that cycle only.
REQ-018 SHALL go from SHIFT to START with idx=0; START drives stage_start[idx]=1 for one cycle, then goes to WAIT.
REQ-019 SHALL ignore stage_done during START and sample it only in WAIT.
REQ-020 SHALL, in WAIT on stage_done[idx]=1, go to CACHE if CACHE_MASK[idx] is 1, else to START with idx+1, or to DONE after the last stage.
REQ-021 SHALL drive cache_clk[idx]=1 for one cycle in CACHE, then go to START with idx+1, or to DONE after the last stage.
REQ-022 SHALL, in DONE, pulse frame_done for one cycle, latch last_cycles, update max_cycles if larger, and return to IDLE.
REQ-023 SHALL keep busy=1 in every state except IDLE.
REQ-024 SHALL count frame cycles from t (value 0 at t); last_cycles equals the count in the DONE cycle; the counter saturates at all-ones.
REQ-025 SHALL, on an edge while busy, set overrun sticky, abort the frame without frame_done or a stats update, and restart at SHIFT on the next cycle.
REQ-026 SHALL, when WAIT lasts TIMEOUT cycles without done, set timeout_err sticky and go to IDLE without frame_done.
REQ-027 SHALL, on an edge in the same cycle as a timeout, give precedence to the edge (overrun plus timeout both set, restart at SHIFT).
REQ-028 SHALL clear overrun, timeout_err and max_cycles on clr_stats; a set event in the same cycle wins over the clear.
REQ-029 SHALL keep stage_start, cache_clk and lsb_clk one-hot-or-zero and registered (glitch-free).

Reset
REQ-030 SHALL, on rst, force state IDLE, idx 0, previous sample_clk 0, and all outputs and counters 0.
REQ-031 SHALL treat rst mid-frame as an immediate abort, with no pulse emitted in the following cycle.
REQ-032 SHALL not detect an edge in the first cycle after rst if sample_clk is already high.

Structure
REQ-033 SHALL place the state enum and the default TIMEOUT and CW constants in a shared package, nn_sched_pkg.
REQ-034 SHALL use one sub-module, rise_detect, for the sample_clk edge register.

Verification
REQ-035 SHALL verify: N=2, CACHE_MASK=01, each stage answers done 3 cycles after start -> lsb_clk at t+1, start0 at t+2, cache_clk[0] at t+6, start1 at t+7, frame_done at t+11, last_cycles=11.
REQ-036 SHALL verify: a second edge at t+4 in that setup -> overrun=1, no frame_done, lsb_clk at t+5, and the restarted frame completes with last_cycles=11.
REQ-037 SHALL verify: TIMEOUT=8 with stage 0 never done -> timeout_err=1 at t+10, busy=0 at t+11, and stage 1 never starts.
REQ-038 SHALL verify: stage_done held high continuously -> the done in the START cycle is ignored, and the stage advances in the first WAIT cycle.
REQ-039 SHALL verify: frames of 11 then 9 cycles -> max_cycles=11, last_cycles=9; clr_stats -> max_cycles=0.
REQ-040 SHALL verify: rst asserted in WAIT -> all outputs 0 the next cycle, and the next edge starts a clean frame.
